// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the rule that sizes the iteration counter.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width needed to count 0..width-1 iterations.
  function automatic int cntWidth(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/borrow_look_ahead_sub.sv
// N-bit borrow-look-ahead subtractor: o_diff = i_a - i_b, o_bout set when
// i_a < i_b (unsigned). Purely combinational.
module borrow_look_ahead_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_bout
);

  logic [N-1:0] w_gen;
  logic [N-1:0] w_prop;
  logic [N:0]   w_borrow;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  assign w_gen  = ~i_a & i_b;
  assign w_prop = ~(i_a ^ i_b);

  assign w_borrow[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_chain
    assign w_borrow[i+1] = w_gen[i] | (w_prop[i] & w_borrow[i]);
  end

  assign o_diff = i_a ^ i_b ^ w_borrow[N-1:0];
  assign o_bout = w_borrow[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider. One quotient bit per clock using a
// single borrow-look-ahead subtractor; divide-by-zero finishes immediately.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = cntWidth(WIDTH);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_divZero;
  logic             w_lastIter;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;
  logic             w_bout;
  logic [WIDTH:0]   w_rNext;
  logic [WIDTH-1:0] w_qNext;
  logic             w_busyNext;
  logic             w_doneNext;
  logic             w_unused;

  assign w_accept   = (r_state == IDLE) && i_start;
  assign w_divZero  = (i_divisor == '0);
  assign w_lastIter = (r_cnt == CW'(WIDTH - 1));

  // Partial remainder shifted left with the next dividend bit brought in.
  assign w_shifted = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

  borrow_look_ahead_sub #(
    .N(WIDTH + 1)
  ) u_sub (
    .i_a    (w_shifted),
    .i_b    ({1'b0, r_d}),
    .o_diff (w_diff),
    .o_bout (w_bout)
  );

  // Restoring step: keep the difference only when the subtraction fits.
  assign w_rNext = w_bout ? w_shifted : w_diff;
  assign w_qNext = {r_q[WIDTH-2:0], ~w_bout};

  // The top remainder bit is always zero after a restoring step; it only
  // exists so the shifted value has room during the compare.
  assign w_unused = r_r[WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic.
  always_comb begin
    w_nextState = IDLE;
    case (r_state)
      IDLE:    w_nextState = i_start ? (w_divZero ? DONE : RUN) : IDLE;
      RUN:     w_nextState = w_lastIter ? DONE : RUN;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Status flags for the coming cycle, registered below.
  always_comb begin
    w_busyNext = (w_nextState != IDLE);
    w_doneNext = (w_nextState == DONE);
  end

  // Registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_busy <= w_busyNext;
      o_done <= w_doneNext;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q           <= '0;
      r_d           <= '0;
      r_r           <= '0;
      r_cnt         <= '0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_q   <= i_dividend;
      r_d   <= i_divisor;
      r_r   <= '0;
      r_cnt <= '0;
      if (w_divZero) begin
        o_quotient    <= '1;
        o_remainder   <= i_dividend;
        o_div_by_zero <= 1'b1;
      end else begin
        o_div_by_zero <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_r   <= w_rNext;
      r_q   <= w_qNext;
      r_cnt <= r_cnt + CW'(1);
      if (w_lastIter) begin
        o_quotient  <= w_qNext;
        o_remainder <= w_rNext[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider (WIDTH=8): directed vectors with
// literal expectations plus a per-cycle comparison against an arithmetic model.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_dividend = '0;
  logic [W-1:0] i_divisor = '0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic         o_div_by_zero;

  int vecCount = 0;
  int missCount = 0;

  // Model state: edges counted from the first posedge out of reset.
  int           edgeN = 0;
  int           mAcceptEdge = -1;
  int           mDoneEdge = -1;
  int           mReadyEdge = 0;
  bit           pendValid = 1'b0;
  logic [W-1:0] pendQ = '0;
  logic [W-1:0] pendR = '0;
  logic [W-1:0] expQ = '0;
  logic [W-1:0] expR = '0;
  logic         expDbz = 1'b0;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  bit           sweepOn = 1'b0;
  int           lastDone = -1;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: results from / and %, timing from the latency rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mAcceptEdge = -1;
      mDoneEdge   = -1;
      mReadyEdge  = 0;
      pendValid   = 1'b0;
      expQ        = '0;
      expR        = '0;
      expDbz      = 1'b0;
    end else begin
      edgeN++;
      if (pendValid && edgeN == mDoneEdge) begin
        expQ      = pendQ;
        expR      = pendR;
        pendValid = 1'b0;
      end
      if (i_start && edgeN >= mReadyEdge) begin
        mAcceptEdge = edgeN;
        opA = i_dividend;
        opB = i_divisor;
        if (i_divisor == 0) begin
          expQ      = '1;
          expR      = i_dividend;
          expDbz    = 1'b1;
          mDoneEdge = edgeN;
        end else begin
          expDbz    = 1'b0;
          pendQ     = i_dividend / i_divisor;
          pendR     = i_dividend % i_divisor;
          pendValid = 1'b1;
          mDoneEdge = edgeN + W;
        end
        mReadyEdge = mDoneEdge + 2;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    logic expBusy;
    logic expDone;
    expBusy = rst_n && mAcceptEdge >= 0 && edgeN >= mAcceptEdge && edgeN <= mDoneEdge;
    expDone = rst_n && mDoneEdge >= 0 && edgeN == mDoneEdge;
    checkOutput("busy", o_busy, expBusy);
    checkOutput("done", o_done, expDone);
    checkOutput("quotient", o_quotient, expQ);
    checkOutput("remainder", o_remainder, expR);
    checkOutput("divByZero", o_div_by_zero, expDbz);
    if (rst_n && o_done === 1'b1 && o_div_by_zero === 1'b0 && opB != 0) begin
      checkOutput("invariant", int'(o_quotient) * int'(opB) + int'(o_remainder), opA);
      checkOutput("remLtDivisor", o_remainder < opB, 1);
    end
    if (o_done === 1'b1) begin
      if (sweepOn && lastDone >= 0) checkOutput("doneSpacing", edgeN - lastDone, W + 2);
      lastDone = edgeN;
    end
  end

  // Pulse start for one cycle; returns at the falling edge after the sampling edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    i_start    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Count cycles after the accepting edge until done, bounded.
  task automatic waitDone(output int k);
    k = 1;
    while (o_done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (o_done !== 1'b1) checkOutput("doneTimeout", o_done, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t table1 [3] = '{
    '{8'd255, 8'd1,   8'd255, 8'd0},
    '{8'd3,   8'd10,  8'd0,   8'd3},
    '{8'd200, 8'd200, 8'd1,   8'd0}
  };

  initial begin
    int k;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", o_busy, 0);
    checkOutput("rstDone", o_done, 0);
    checkOutput("rstQuotient", o_quotient, 0);
    checkOutput("rstRemainder", o_remainder, 0);
    checkOutput("rstDivByZero", o_div_by_zero, 0);
    rst_n = 1'b1;

    applyStimulus(8'd100, 8'd7);
    waitDone(k);
    checkOutput("latency100div7", k, 9);
    checkOutput("q100div7", o_quotient, 14);
    checkOutput("r100div7", o_remainder, 2);
    checkOutput("dbz100div7", o_div_by_zero, 0);

    foreach (table1[i]) begin
      applyStimulus(table1[i].a, table1[i].b);
      waitDone(k);
      checkOutput("latencyTable", k, 9);
      checkOutput("qTable", o_quotient, table1[i].q);
      checkOutput("rTable", o_remainder, table1[i].r);
    end

    applyStimulus(8'd5, 8'd0);
    waitDone(k);
    checkOutput("latencyDivZero", k, 1);
    checkOutput("qDivZero", o_quotient, 255);
    checkOutput("rDivZero", o_remainder, 5);
    checkOutput("dbzDivZero", o_div_by_zero, 1);

    applyStimulus(8'd9, 8'd3);
    waitDone(k);
    checkOutput("q9div3", o_quotient, 3);
    checkOutput("r9div3", o_remainder, 0);
    checkOutput("dbz9div3", o_div_by_zero, 0);

    applyStimulus(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    i_start    = 1'b1;
    i_dividend = 8'd50;
    i_divisor  = 8'd5;
    @(negedge clk);
    i_start = 1'b0;
    waitDone(k);
    checkOutput("qIgnored", o_quotient, 14);
    checkOutput("rIgnored", o_remainder, 2);
    repeat (12) @(negedge clk);

    applyStimulus(8'd100, 8'd7);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", o_busy, 0);
    checkOutput("abortDone", o_done, 0);
    checkOutput("abortQuotient", o_quotient, 0);
    checkOutput("abortRemainder", o_remainder, 0);
    checkOutput("abortDivByZero", o_div_by_zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd17, 8'd4);
    waitDone(k);
    checkOutput("q17div4", o_quotient, 4);
    checkOutput("r17div4", o_remainder, 1);

    lastDone = -1;
    sweepOn  = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      i_start    = 1'b1;
      i_dividend = W'($urandom_range(0, 255));
      i_divisor  = W'($urandom_range(1, 255));
      @(negedge clk);
      i_start = 1'b0;
      repeat (W) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    sweepOn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
